fifo_rd_packetizer: RTL and testbench
=====================================

// Module: fifo_rd_packetizer
// PURPOSE
//  Read-side drain stage on the async FIFO's r_clk domain. Pops words from the FIFO
//  and presents them on a valid/ready stream, framing packets with m_last.
//  One word of lookahead is held so m_last is known when each word is presented.
//  Feeds the downstream packet consumer.
// PARAMETERS
//  DATA_WIDTH   8   width of fifo_data / m_data
//  PKT_LEN      4   words per full packet (>=1); m_last on every PKT_LEN-th word
//  TIMEOUT_CYC  16  consecutive starved cycles before a partial packet is closed (>=1)
// PORTS
//  clk         in   1           read-domain clock (same clock as the FIFO r_clk)
//  rst         in   1           synchronous, active-high reset
//  fifo_empty  in   1           FIFO empty flag
//  fifo_data   in   DATA_WIDTH  FIFO head word, valid whenever !fifo_empty (fall-through)
//  fifo_r_en   out  1           pop strobe to the FIFO r_en
//  m_valid     out  1           output word valid
//  m_ready     in   1           downstream accepts when m_valid & m_ready
//  m_data      out  DATA_WIDTH  output word
//  m_last      out  1           final word of a packet
//  pkt_cnt     out  16          packets closed since reset, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset: clk, with synchronous active-high rst. While rst=1: fifo_r_en=0. After the edge:
//   m_valid=0, m_last=0, m_data=0, pkt_cnt=0; internal pend_v=0, word_cnt=0, idle_cnt=0.
//   Asserting rst mid-packet discards the pending and output words; no m_last is issued.
//  Internal state: pending reg (pend_v, pend_d); word_cnt, 0..PKT_LEN-1, counting words emitted
//   in the current packet.
//  out_free = !m_valid | m_ready
//  close    = (word_cnt == PKT_LEN-1) | tmo_hit
//  advance  = pend_v & out_free & (!fifo_empty | close)
//  fifo_r_en = !rst & !fifo_empty & (!pend_v | advance). Combinational; may depend on m_ready.
//  On fifo_r_en: pend_d <= fifo_data, pend_v <= 1. Else on advance: pend_v <= 0.
//  On advance: m_data <= pend_d, m_valid <= 1, m_last <= close.
//   Also word_cnt <= close ? 0 : word_cnt+1, and pkt_cnt += close.
//  Else, if m_ready: m_valid <= 0. m_data and m_last hold while m_valid & !m_ready.
//  Minimum latency is 2 clk from the fifo_r_en cycle to m_valid (PKT_LEN=1, or next word present).
//  Throughput is 1 word/clk while the FIFO is non-empty and m_ready=1.
//  FIFO empty with a pending word and not at a boundary: the word is held. It is not presented
//   until the next word arrives or a timeout closes the packet.
//  Simultaneous pop and advance: same cycle is allowed, pending reg refills without a bubble.
//  word_cnt wraps exactly at PKT_LEN. A packet never exceeds PKT_LEN words.
// CONFIGURATION
//  Macro FIFO_RD_TIMEOUT_EN.
//  Defined: idle_cnt increments each cycle that pend_v & fifo_empty & !advance, saturating at
//   TIMEOUT_CYC. It clears on fifo_r_en, on advance, or on rst. tmo_hit = (idle_cnt == TIMEOUT_CYC).
//   The pending word is then emitted with m_last=1 once out_free.
//  Undefined: tmo_hit is tied to 0 and idle_cnt is not built. A partial packet waits indefinitely.
// STRUCTURE
//  Package fifo_rd_pkg:
//   - DATA_WIDTH default
//   - typedef logic [DATA_WIDTH-1:0] word_t
//   - typedef logic [15:0] pkt_cnt_t
//   - localparam function for the word_cnt width: $clog2(PKT_LEN), minimum 1
//  One sub-module, fifo_rd_timer: the idle counter and tmo_hit, instantiated only under
//   FIFO_RD_TIMEOUT_EN. Everything else stays in this module.
// TESTING
//  1 Reset: rst for 2 clk with fifo_empty=0 -> fifo_r_en=0 throughout; outputs 0 afterwards.
//  2 Stream: PKT_LEN=4, push 8 words 0x10..0x17, m_ready=1 -> 8 back-to-back beats 0x10..0x17.
//    m_last is set on 0x13 and 0x17; pkt_cnt=2.
//  3 Backpressure: m_ready=0 for 5 clk mid-packet -> m_data/m_last stable, no extra fifo_r_en.
//    Order preserved after release.
//  4 Timeout (macro on, TIMEOUT_CYC=16): push 2 words 0xA0,0xA1, then starve.
//    -> 0xA0 is emitted with last=0. 0xA1 is emitted 16 clk after the FIFO goes empty, with
//    last=1. pkt_cnt=1.
//  5 Timeout (macro off): same stimulus -> 0xA1 is never presented. Push 0xA2 later ->
//    0xA1 is emitted with last=0.
//  6 Reset mid-packet after 2 words -> m_valid=0 next clk. The next 4 words form a fresh
//    packet, with last on the 4th.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// Shared types and sizing helpers for the FIFO read-side packetizer.
package fifo_rd_pkg;

  localparam int unsigned DATA_WIDTH = 8;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [15:0]           pkt_cnt_t;

  // Width of a counter holding 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_rd_timer.sv
// Starvation timer for fifo_rd_packetizer (only built with FIFO_RD_TIMEOUT_EN).
// Counts consecutive cycles a pending word sits with the FIFO empty and flags
// when a partial packet should be closed.
module fifo_rd_timer #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic pend_v,
  input  logic fifo_empty,
  input  logic advance,
  input  logic fifo_r_en,
  output logic tmo_hit
);

  localparam int unsigned          IdleW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IdleW-1:0]     IdleMax = IdleW'(TIMEOUT_CYC);

  logic [IdleW-1:0] idle_cnt;

  // Saturating idle counter; any pop or emitted word restarts the wait.
  always_ff @(posedge clk) begin
    if (rst || fifo_r_en || advance) begin
      idle_cnt <= '0;
    end else if (pend_v && fifo_empty && (idle_cnt != IdleMax)) begin
      idle_cnt <= idle_cnt + IdleW'(1);
    end
  end

  assign tmo_hit = (idle_cnt == IdleMax);

endmodule

// File: rtl/fifo_rd_packetizer.sv
// Read-side drain stage: pops a fall-through FIFO and presents words on a
// valid/ready stream framed with m_last. One word is held in a pending register
// so the framing of each word is known before it is presented.
// Optional feature: define FIFO_RD_TIMEOUT_EN to close a starved partial packet
// after TIMEOUT_CYC idle cycles; otherwise a partial packet waits indefinitely.
module fifo_rd_packetizer
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = fifo_rd_pkg::DATA_WIDTH,
  parameter int unsigned PKT_LEN     = 4,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_r_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output pkt_cnt_t              pkt_cnt
);

  localparam int unsigned     CntW    = cnt_width(PKT_LEN);
  localparam logic [CntW-1:0] LastIdx = CntW'(PKT_LEN - 1);

  logic                  pend_v;
  logic [DATA_WIDTH-1:0] pend_d;
  logic [CntW-1:0]       word_cnt;
  logic                  out_free;
  logic                  close;
  logic                  advance;
  logic                  tmo_hit;

`ifdef FIFO_RD_TIMEOUT_EN
  fifo_rd_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .pend_v    (pend_v),
    .fifo_empty(fifo_empty),
    .advance   (advance),
    .fifo_r_en (fifo_r_en),
    .tmo_hit   (tmo_hit)
  );
`else
  assign tmo_hit = 1'b0;
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC == 0);
`endif

  // Handshake decode: a pending word moves out only when the output slot is free
  // and either its successor is visible (not last) or it must close the packet.
  always_comb begin
    out_free  = !m_valid || m_ready;
    close     = (word_cnt == LastIdx) || tmo_hit;
    advance   = pend_v && out_free && (!fifo_empty || close);
    fifo_r_en = !rst && !fifo_empty && (!pend_v || advance);
  end

  // Lookahead register; a pop in the same cycle as an advance refills it directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_v <= 1'b0;
      pend_d <= '0;
    end else if (fifo_r_en) begin
      pend_v <= 1'b1;
      pend_d <= fifo_data;
    end else if (advance) begin
      pend_v <= 1'b0;
    end
  end

  // Output slot plus per-packet word count and closed-packet counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_last   <= 1'b0;
      word_cnt <= '0;
      pkt_cnt  <= '0;
    end else if (advance) begin
      m_valid  <= 1'b1;
      m_data   <= pend_d;
      m_last   <= close;
      word_cnt <= close ? '0 : word_cnt + CntW'(1);
      pkt_cnt  <= pkt_cnt + pkt_cnt_t'(close);
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_rd_packetizer.sv
// Directed bench for fifo_rd_packetizer (PKT_LEN=4, TIMEOUT_CYC=16).
// Follows FIFO_RD_TIMEOUT_EN so the timeout scenario matches the build.
module tb_fifo_rd_packetizer;
  import fifo_rd_pkg::*;

  localparam int unsigned PktLen     = 4;
  localparam int unsigned TimeoutCyc = 16;

  logic     clk = 1'b0;
  logic     rst;
  logic     fifo_empty;
  word_t    fifo_data;
  logic     fifo_r_en;
  logic     m_valid;
  logic     m_ready;
  word_t    m_data;
  logic     m_last;
  pkt_cnt_t pkt_cnt;

  always #5 clk = ~clk;

  fifo_rd_packetizer #(
    .DATA_WIDTH (8),
    .PKT_LEN    (PktLen),
    .TIMEOUT_CYC(TimeoutCyc)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_r_en (fifo_r_en),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .pkt_cnt   (pkt_cnt)
  );

  word_t fq[$];      // FIFO contents, head at index 0
  word_t got_d[$];   // accepted beats
  logic  got_l[$];
  int    got_c[$];   // cycle index of each accepted beat
  int    cyc;
  int    checks;
  int    errors;
  int    c_load;
  logic  s_ren, s_valid, s_last;
  word_t s_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fifo_drive();
    fifo_empty = (fq.size() == 0);
    fifo_data  = (fq.size() != 0) ? fq[0] : '0;
  endtask

  task automatic clr_got();
    got_d.delete();
    got_l.delete();
    got_c.delete();
  endtask

  // One clock: sample mid-cycle, then apply the FIFO pop after the edge.
  task automatic tick();
    @(negedge clk);
    s_ren   = fifo_r_en;
    s_valid = m_valid;
    s_data  = m_data;
    s_last  = m_last;
    if (m_valid && m_ready) begin
      got_d.push_back(m_data);
      got_l.push_back(m_last);
      got_c.push_back(cyc);
    end
    @(posedge clk);
    #1;
    if (s_ren && fq.size() > 0) void'(fq.pop_front());
    cyc++;
    fifo_drive();
  endtask

  task automatic run_until(input int n, input int budget);
    for (int k = 0; k < budget && got_d.size() < n; k++) tick();
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    cyc     = 0;
    m_ready = 1'b1;
    rst     = 1'b1;

    // 1: reset with a non-empty FIFO must never pop
    fq.push_back(8'h55);
    fifo_drive();
    tick();
    chk("rst_ren0", {31'd0, s_ren}, 32'd0);
    tick();
    chk("rst_ren1", {31'd0, s_ren}, 32'd0);
    fq.delete();
    fifo_drive();
    rst = 1'b0;
    chk("rst_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_last", {31'd0, m_last}, 32'd0);
    chk("rst_data", {24'd0, m_data}, 32'd0);
    chk("rst_pkt", {16'd0, pkt_cnt}, 32'd0);

    // 2: streaming, two full packets back to back
    clr_got();
    for (int i = 0; i < 8; i++) fq.push_back(word_t'(8'h10 + i));
    fifo_drive();
    run_until(8, 40);
    chk("s2_count", got_d.size(), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("s2_data", {24'd0, got_d[i]}, 32'h10 + i);
      chk("s2_last", {31'd0, got_l[i]}, {31'd0, (i % 4) == 3});
    end
    chk("s2_b2b", got_c[7] - got_c[0], 32'd7);
    chk("s2_pkt", {16'd0, pkt_cnt}, 32'd2);

    // 3: backpressure while 0x21 is presented
    clr_got();
    for (int i = 0; i < 8; i++) fq.push_back(word_t'(8'h20 + i));
    fifo_drive();
    tick();
    tick();
    tick();
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", {31'd0, s_valid}, 32'd1);
      chk("bp_data", {24'd0, s_data}, 32'h21);
      chk("bp_last", {31'd0, s_last}, 32'd0);
      chk("bp_ren", {31'd0, s_ren}, 32'd0);
    end
    m_ready = 1'b1;
    run_until(8, 40);
    chk("bp_count", got_d.size(), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("bp_order", {24'd0, got_d[i]}, 32'h20 + i);
      chk("bp_lastf", {31'd0, got_l[i]}, {31'd0, (i % 4) == 3});
    end
    chk("bp_pkt", {16'd0, pkt_cnt}, 32'd4);

    // 4/5: two words then starvation
    clr_got();
    c_load = cyc;
    fq.push_back(8'hA0);
    fq.push_back(8'hA1);
    fifo_drive();
    run_until(1, 10);
    chk("to_a0", {24'd0, got_d[0]}, 32'hA0);
    chk("to_a0_last", {31'd0, got_l[0]}, 32'd0);
    // FIFO is empty from cycle c_load+2 onward
    chk("to_a0_cyc", got_c[0] - c_load, 32'd2);
`ifdef FIFO_RD_TIMEOUT_EN
    run_until(2, 40);
    chk("to_count", got_d.size(), 32'd2);
    chk("to_a1", {24'd0, got_d[1]}, 32'hA1);
    chk("to_a1_last", {31'd0, got_l[1]}, 32'd1);
    // 16 starved cycles, the cycle where tmo_hit advances, then the registered beat
    chk("to_a1_cyc", got_c[1] - (c_load + 2), TimeoutCyc + 1);
    chk("to_pkt", {16'd0, pkt_cnt}, 32'd5);
`else
    for (int i = 0; i < 40; i++) tick();
    chk("nto_count", got_d.size(), 32'd1);
    chk("nto_valid", {31'd0, s_valid}, 32'd0);
    fq.push_back(8'hA2);
    fifo_drive();
    run_until(2, 10);
    chk("nto_count2", got_d.size(), 32'd2);
    chk("nto_a1", {24'd0, got_d[1]}, 32'hA1);
    chk("nto_a1_last", {31'd0, got_l[1]}, 32'd0);
    chk("nto_pkt", {16'd0, pkt_cnt}, 32'd4);
`endif

    // 6: clean start, then reset after two words with the second one stalled
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clr_got();
    fq.push_back(8'hB0);
    fq.push_back(8'hB1);
    fq.push_back(8'hB2);
    fifo_drive();
    tick();
    tick();
    tick();
    chk("mr_b0", {24'd0, got_d[0]}, 32'hB0);
    m_ready = 1'b0;
    rst     = 1'b1;
    tick();
    chk("mr_ren", {31'd0, s_ren}, 32'd0);
    chk("mr_valid", {31'd0, m_valid}, 32'd0);
    chk("mr_last", {31'd0, m_last}, 32'd0);
    chk("mr_data", {24'd0, m_data}, 32'd0);
    chk("mr_pkt", {16'd0, pkt_cnt}, 32'd0);
    chk("mr_count", got_d.size(), 32'd1);
    rst     = 1'b0;
    m_ready = 1'b1;
    clr_got();
    for (int i = 0; i < 4; i++) fq.push_back(word_t'(8'hC0 + i));
    fifo_drive();
    run_until(4, 20);
    chk("mr_count2", got_d.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("mr_cdata", {24'd0, got_d[i]}, 32'hC0 + i);
      chk("mr_clast", {31'd0, got_l[i]}, {31'd0, i == 3});
    end
    chk("mr_pkt2", {16'd0, pkt_cnt}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
